debounce_edge_gen: RTL and testbench

- Conditions a raw, asynchronous push-button/switch input into a clean, single-clock-domain level and one-cycle edge pulses.
- Sits directly upstream of the board's D flip-flop stages: D_OUT drives their D input; RISE/FALL serve as clock-enable style strobes.
- Also keeps a wrap-around count of accepted presses for display logic.

---
 rtl/debounce_edge_gen_if.sv | 26 ++
 rtl/debounce_edge_gen.sv | 137 +++++++++++++
 tb/tb_debounce_edge_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/debounce_edge_gen_if.sv
// Button-side signal bundle for debounce_edge_gen: raw level in, clean level,
// edge strobes and press count out.
interface debounce_edge_gen_if;
    logic       BTN;
    logic       D_OUT;
    logic       RISE;
    logic       FALL;
    logic [7:0] PRESS_CNT;

    // master drives the raw button; slave is the debouncer itself
    modport master (
        output BTN,
        input  D_OUT,
        input  RISE,
        input  FALL,
        input  PRESS_CNT
    );

    modport slave (
        input  BTN,
        output D_OUT,
        output RISE,
        output FALL,
        output PRESS_CNT
    );
endinterface

// File: rtl/debounce_edge_gen.sv
// Two-flop synchronizer plus stability-counting FSM: turns a bouncy button into
// a clean level, one-cycle RISE/FALL strobes and a modulo-256 press count.
module debounce_edge_gen #(
    parameter int unsigned CNT_MAX = 1000000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    debounce_edge_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_done;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             r_dout;
    logic             r_rise;
    logic             r_fall;
    logic [7:0]       r_press;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= bus.BTN;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_cnt_done = (r_cnt == LP_CNT_LAST);

    // Counter restarts on every state change so a partial run never carries over
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (r_s2) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                if (r_s2) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_rise_nxt = 1'b0;
        w_fall_nxt = 1'b0;
        if (r_state == WAIT_HIGH && r_s2 && w_cnt_done) begin
            w_rise_nxt = 1'b1;
        end
        if (r_state == WAIT_LOW && !r_s2 && w_cnt_done) begin
            w_fall_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_press <= '0;
        end else begin
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            if (w_rise_nxt) begin
                r_dout  <= 1'b1;
                r_press <= r_press + 8'd1;
            end else if (w_fall_nxt) begin
                r_dout  <= 1'b0;
            end
        end
    end

    assign bus.D_OUT     = r_dout;
    assign bus.RISE      = r_rise;
    assign bus.FALL      = r_fall;
    assign bus.PRESS_CNT = r_press;

endmodule

// File: tb/tb_debounce_edge_gen.sv
// Randomized and directed checks of debounce_edge_gen against a run-length
// reference model: a level is accepted once CNT_MAX+1 consecutive samples differ.
module tb_debounce_edge_gen;

    localparam int unsigned P_CNT_MAX = 4;
    localparam int unsigned P_CNT_W   = 3;

    logic CLK;
    logic RST_n;

    debounce_edge_gen_if bus ();

    debounce_edge_gen #(
        .CNT_MAX (P_CNT_MAX),
        .CNT_W   (P_CNT_W)
    ) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec;
    int n_err;

    logic m_hist[$];
    logic m_lvl;
    logic m_rise;
    logic m_fall;
    int   m_run;
    int   m_press;
    int   n_rise;
    int   n_step;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
        m_lvl   = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_run   = 0;
        m_press = 0;
    endtask

    // The FSM sees the button two edges late; acceptance is a run-length rule
    task automatic model_edge(input logic b);
        logic s;
        s = m_hist.pop_front();
        m_hist.push_back(b);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_lvl) begin
            m_run++;
            if (m_run == int'(P_CNT_MAX) + 1) begin
                m_lvl = s;
                m_run = 0;
                if (s) begin
                    m_rise  = 1'b1;
                    m_press = (m_press + 1) % 256;
                end else begin
                    m_fall  = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check_outputs();
        chk("d_out", 32'(bus.D_OUT), 32'(m_lvl));
        chk("rise",  32'(bus.RISE),  32'(m_rise));
        chk("fall",  32'(bus.FALL),  32'(m_fall));
        chk("press", 32'(bus.PRESS_CNT), 32'(m_press));
    endtask

    task automatic step(input logic b);
        @(negedge CLK);
        bus.BTN = b;
        @(posedge CLK);
        model_edge(b);
        #1;
        n_step++;
        if (bus.RISE) n_rise++;
        check_outputs();
    endtask

    task automatic hard_reset();
        @(negedge CLK);
        RST_n   = 1'b0;
        bus.BTN = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int base;
        int prev_press;
        logic lv;
        int len;

        n_vec  = 0;
        n_err  = 0;
        n_rise = 0;
        n_step = 0;
        RST_n   = 1'b0;
        bus.BTN = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;
        #1;
        check_outputs();

        // clean press: rise must follow the first high sample by exactly 7 edges
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1);
            if (bus.RISE && lat < 0) lat = i;
        end
        chk("rise_latency", 32'(lat), 32'd7);
        chk("press_after_clean", 32'(bus.PRESS_CNT), 32'd1);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0);
            if (bus.FALL && lat < 0) lat = i;
        end
        chk("fall_latency", 32'(lat), 32'd7);

        // asynchronous reset mid-cycle while the button is held and D_OUT is high
        for (int i = 0; i < 10; i++) step(1'b1);
        chk("pre_reset_dout", 32'(bus.D_OUT), 32'd1);
        @(negedge CLK);
        bus.BTN = 1'b1;
        #2;
        RST_n = 1'b0;
        #1;
        chk("async_rst_dout",  32'(bus.D_OUT), 32'd0);
        chk("async_rst_press", 32'(bus.PRESS_CNT), 32'd0);
        chk("async_rst_rise",  32'(bus.RISE), 32'd0);
        @(negedge CLK);
        bus.BTN = 1'b0;
        RST_n   = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) step(1'b0);

        // high run of CNT_MAX edges is rejected, CNT_MAX+1 is accepted
        prev_press = int'(bus.PRESS_CNT);
        base = n_rise;
        for (int i = 0; i < 4; i++) step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
        chk("short_press_cnt", 32'(bus.PRESS_CNT), 32'(prev_press));
        chk("short_rise_n", 32'(n_rise - base), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
        chk("min_press_cnt", 32'(bus.PRESS_CNT), 32'((prev_press + 1) % 256));
        chk("min_rise_n", 32'(n_rise - base), 32'd1);

        // bouncy press: single rise 7 edges after the final rising sample
        base = n_rise;
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        lat = -1;
        for (int i = 1; i <= 15; i++) begin
            step(1'b1);
            if (bus.RISE && lat < 0) lat = i;
        end
        chk("bouncy_latency", 32'(lat), 32'd7);
        chk("bouncy_rise_n", 32'(n_rise - base), 32'd1);

        // two-edge low glitch while accepted high
        step(1'b0); step(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1);
        chk("glitch_dout", 32'(bus.D_OUT), 32'd1);

        // random runs of 1..7 edges
        lv = 1'b0;
        for (int r = 0; r < 300; r++) begin
            lv  = ~lv;
            len = int'($urandom_range(7, 1));
            for (int i = 0; i < len; i++) step(lv);
        end

        // 256 clean presses wrap the press counter back to zero
        hard_reset();
        base = n_rise;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 7; i++) step(1'b1);
            for (int i = 0; i < 7; i++) step(1'b0);
        end
        chk("wrap_rise_n", 32'(n_rise - base), 32'd256);
        chk("wrap_press", 32'(bus.PRESS_CNT), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
